fft_reorder: RTL and testbench

Bit-reversal reorder buffer sitting directly downstream of `fft_top`, consuming its `out_push_F`/`out_real_F`/`out_imag_F` stream. Collects each N-point frame, which arrives in bit-reversed bin order, and re-emits it in natural bin order (bin 0 first) on a push/stall interface. Ping-pong double buffering sustains one sample per cycle with one-frame buffering latency.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_pingpong_ram.sv | 28 ++
 rtl/fft_reorder.sv | 123 ++++++++++++
 tb/tb_fft_reorder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample type and bin-index bit reversal,
// used by fft_top and by the reorder buffer downstream of it.
package fft_pkg;

    localparam int FFT_WIDTH = 16;
    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    // Reverses the low w bits of a; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i[4:0]] = a[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store for the reorder buffer: one synchronous write port,
// one asynchronous read port, bank select carried as the address MSB.
module fft_pingpong_ram #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG2N:0]       waddr,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [LOG2N:0]       raddr,
    output logic [2*WIDTH-1:0]   rdata
);

    localparam int DEPTH = 2 ** (LOG2N + 1);

    // Contents are never reset; a bank is only read after it has been fully written.
    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversal reorder buffer: collects bit-reversed FFT frames into a
// ping-pong store and replays each one in natural bin order on push/stall.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_push,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    in_stall,
    output logic                    out_push,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    input  logic                    out_stall
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [1:0]              full_q, full_d;
    logic                    wsel_q, wsel_d;
    logic                    rsel_q, rsel_d;
    logic [LOG2N-1:0]        wcnt_q, wcnt_d;
    logic [LOG2N-1:0]        rcnt_q, rcnt_d;
    logic                    out_push_q, out_push_d;
    logic signed [WIDTH-1:0] out_real_q, out_real_d;
    logic signed [WIDTH-1:0] out_imag_q, out_imag_d;

    logic                    wr_en;
    logic                    rd_en;
    logic [LOG2N-1:0]        wr_bin;
    logic [LOG2N:0]          waddr;
    logic [LOG2N:0]          raddr;
    logic [2*WIDTH-1:0]      wdata;
    logic [2*WIDTH-1:0]      rdata;

    // Backpressure comes from registered flags only, never from out_stall.
    assign in_stall = full_q[wsel_q];
    assign wr_en    = in_push && !full_q[wsel_q];
    assign rd_en    = full_q[rsel_q] && (!out_push_q || !out_stall);

    assign wr_bin = LOG2N'(bitrev(32'(wcnt_q), unsigned'(LOG2N)));
    assign waddr  = {wsel_q, wr_bin};
    assign raddr  = {rsel_q, rcnt_q};
    assign wdata  = {in_real, in_imag};

    fft_pingpong_ram #(
        .WIDTH (WIDTH),
        .LOG2N (LOG2N)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        full_d     = full_q;
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        out_push_d = out_push_q;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;

        if (wr_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = !wsel_q;
            end
        end

        // Write only sets an empty bank and read only clears a full one,
        // so a completing write and a releasing read never touch the same flag.
        if (rd_en) begin
            out_push_d = 1'b1;
            out_real_d = $signed(rdata[2*WIDTH-1:WIDTH]);
            out_imag_d = $signed(rdata[WIDTH-1:0]);
            rcnt_d     = rcnt_q + 1'b1;
            if (rcnt_q == LAST) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = !rsel_q;
            end
        end else if (out_push_q && !out_stall) begin
            out_push_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q     <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            out_push_q <= 1'b0;
            out_real_q <= '0;
            out_imag_q <= '0;
        end else begin
            full_q     <= full_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            out_push_q <= out_push_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
        end
    end

    assign out_push = out_push_q;
    assign out_real = out_real_q;
    assign out_imag = out_imag_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: frames arrive in bit-reversed order and
// must come back in natural bin order under the various stall patterns.
module tb_fft_reorder;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        in_push   = 1'b0;
    logic [15:0] in_real   = '0;
    logic [15:0] in_imag   = '0;
    logic        out_stall = 1'b0;
    logic        in_stall;
    logic        out_push;
    logic [15:0] out_real;
    logic [15:0] out_imag;

    int checks   = 0;
    int failures = 0;

    fft_reorder #(
        .WIDTH (16),
        .N     (16),
        .LOG2N (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_push   (in_push),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_stall  (in_stall),
        .out_push  (out_push),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_stall (out_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] br4(input int j);
        logic [3:0] v;
        logic [3:0] r;
        v = j[3:0];
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im);
        in_push = 1'b1;
        in_real = re;
        in_imag = im;
        cyc();
        in_push = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_push !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_push got=%b exp=0", out_push);
        end
        checks++;
        if (out_real !== 16'h0000 || out_imag !== 16'h0000) begin
            failures++;
            $display("FAIL reset_out_data got=%h/%h exp=0000/0000", out_real, out_imag);
        end
        checks++;
        if (in_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_stall got=%b exp=0", in_stall);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        cyc();
    endtask

    task automatic test_single_frame();
        logic [15:0] er, ei;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (in_stall !== 1'b0) begin
                failures++;
                $display("FAIL single_in_stall j=%0d got=%b exp=0", j, in_stall);
            end
            push(16'h0100 + 16'(br4(j)), 16'h0200 + 16'(br4(j)));
        end
        checks++;
        if (out_push !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got=%b exp=0 at last-push edge", out_push);
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            er = 16'h0100 + 16'(i);
            ei = 16'h0200 + 16'(i);
            checks++;
            if (out_push !== 1'b1 || out_real !== er || out_imag !== ei) begin
                failures++;
                $display("FAIL single_out i=%0d got push=%b %h/%h exp push=1 %h/%h",
                         i, out_push, out_real, out_imag, er, ei);
            end
        end
        cyc();
        checks++;
        if (out_push !== 1'b0) begin
            failures++;
            $display("FAIL single_end got=%b exp=0", out_push);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        int m     = 0;
        logic [15:0] er, ei;
        out_stall = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c < 48) begin
                checks++;
                if (in_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_in_stall c=%0d got=%b exp=0", c, in_stall);
                end
                in_push = 1'b1;
                in_real = 16'h0100 + 16'(br4(c % 16));
                in_imag = 16'h0200 + 16'((c / 16) * 256) + 16'(br4(c % 16));
            end else begin
                in_push = 1'b0;
            end
            cyc();
            if (out_push === 1'b1) begin
                er = 16'h0100 + 16'(m % 16);
                ei = 16'h0200 + 16'((m / 16) * 256) + 16'(m % 16);
                checks++;
                if (out_real !== er || out_imag !== ei) begin
                    failures++;
                    $display("FAIL b2b_out m=%0d got=%h/%h exp=%h/%h", m, out_real, out_imag, er, ei);
                end
                if (first < 0) first = c;
                last = c;
                m++;
            end
        end
        in_push = 1'b0;
        checks++;
        if (m != 48) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=48", m);
        end
        checks++;
        if (first != 16 || last != first + 47) begin
            failures++;
            $display("FAIL b2b_gapless got first=%0d last=%0d exp first=16 last=63", first, last);
        end
    endtask

    task automatic test_stall_two_frames();
        int m = 0;
        logic [15:0] er, ei;
        out_stall = 1'b1;
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (in_stall !== 1'b0) begin
                failures++;
                $display("FAIL stall2_early_in_stall c=%0d got=%b exp=0", c, in_stall);
            end
            push(16'h0100 + 16'(br4(c % 16)), 16'h0200 + 16'((c / 16) * 256) + 16'(br4(c % 16)));
        end
        checks++;
        if (in_stall !== 1'b1) begin
            failures++;
            $display("FAIL stall2_in_stall got=%b exp=1", in_stall);
        end
        checks++;
        if (out_push !== 1'b1 || out_real !== 16'h0100 || out_imag !== 16'h0200) begin
            failures++;
            $display("FAIL stall2_hold got push=%b %h/%h exp push=1 0100/0200", out_push, out_real, out_imag);
        end
        push(16'h7E7E, 16'h7E7E);
        checks++;
        if (in_stall !== 1'b1 || out_push !== 1'b1 || out_real !== 16'h0100) begin
            failures++;
            $display("FAIL stall2_ignored got in_stall=%b push=%b real=%h exp 1 1 0100",
                     in_stall, out_push, out_real);
        end
        out_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_push === 1'b1) begin
                er = 16'h0100 + 16'(m % 16);
                ei = 16'h0200 + 16'((m / 16) * 256) + 16'(m % 16);
                checks++;
                if (out_real !== er || out_imag !== ei) begin
                    failures++;
                    $display("FAIL stall2_out m=%0d got=%h/%h exp=%h/%h", m, out_real, out_imag, er, ei);
                end
                if (m == 14) begin
                    checks++;
                    if (in_stall !== 1'b1) begin
                        failures++;
                        $display("FAIL stall2_release_early got=%b exp=1", in_stall);
                    end
                end
                if (m == 15) begin
                    checks++;
                    if (in_stall !== 1'b0) begin
                        failures++;
                        $display("FAIL stall2_release got=%b exp=0", in_stall);
                    end
                end
                m++;
            end
            cyc();
        end
        checks++;
        if (m != 32 || out_push !== 1'b0) begin
            failures++;
            $display("FAIL stall2_count got=%0d push=%b exp=32 push=0", m, out_push);
        end
    endtask

    task automatic test_toggle_stall();
        int m = 0;
        logic st;
        logic was_held;
        logic [15:0] hr, hi, er, ei;
        out_stall = 1'b0;
        hr = '0;
        hi = '0;
        for (int j = 0; j < 16; j++) push(16'h0100 + 16'(br4(j)), 16'h0200 + 16'(br4(j)));
        for (int c = 0; c < 40; c++) begin
            st = (c % 2) == 1;
            out_stall = st;
            if (out_push === 1'b1) begin
                if (!st) begin
                    er = 16'h0100 + 16'(m);
                    ei = 16'h0200 + 16'(m);
                    checks++;
                    if (out_real !== er || out_imag !== ei) begin
                        failures++;
                        $display("FAIL toggle_out m=%0d got=%h/%h exp=%h/%h", m, out_real, out_imag, er, ei);
                    end
                    m++;
                end else begin
                    hr = out_real;
                    hi = out_imag;
                end
            end
            was_held = (out_push === 1'b1) && st;
            cyc();
            if (was_held) begin
                checks++;
                if (out_push !== 1'b1 || out_real !== hr || out_imag !== hi) begin
                    failures++;
                    $display("FAIL toggle_hold c=%0d got push=%b %h/%h exp push=1 %h/%h",
                             c, out_push, out_real, out_imag, hr, hi);
                end
            end
        end
        out_stall = 1'b0;
        checks++;
        if (m != 16 || out_push !== 1'b0) begin
            failures++;
            $display("FAIL toggle_count got=%0d push=%b exp=16 push=0", m, out_push);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] er, ei;
        out_stall = 1'b1;
        for (int j = 0; j < 16; j++) push(16'h5000 + 16'(j), 16'h6000 + 16'(j));
        for (int j = 0; j < 7; j++) push(16'h5500 + 16'(j), 16'h6600 + 16'(j));
        checks++;
        if (out_push !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got push=%b exp=1", out_push);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_push !== 1'b0 || out_real !== 16'h0000 || out_imag !== 16'h0000 || in_stall !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got push=%b %h/%h in_stall=%b exp 0 0000/0000 0",
                     out_push, out_real, out_imag, in_stall);
        end
        out_stall = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        cyc();
        for (int j = 0; j < 16; j++) push(16'h0100 + 16'(br4(j)), 16'h0200 + 16'(br4(j)));
        for (int i = 0; i < 16; i++) begin
            cyc();
            er = 16'h0100 + 16'(i);
            ei = 16'h0200 + 16'(i);
            checks++;
            if (out_push !== 1'b1 || out_real !== er || out_imag !== ei) begin
                failures++;
                $display("FAIL rstmid_out i=%0d got push=%b %h/%h exp push=1 %h/%h",
                         i, out_push, out_real, out_imag, er, ei);
            end
        end
        cyc();
        checks++;
        if (out_push !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_residue got push=%b real=%h exp push=0", out_push, out_real);
        end
    endtask

    task automatic test_push_while_stalled();
        int m = 0;
        logic [15:0] er, ei;
        out_stall = 1'b1;
        for (int c = 0; c < 32; c++)
            push(16'h0100 + 16'(br4(c % 16)), 16'h0200 + 16'((c / 16) * 256) + 16'(br4(c % 16)));
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (in_stall !== 1'b1) begin
                failures++;
                $display("FAIL ignore_in_stall k=%0d got=%b exp=1", k, in_stall);
            end
            push(16'h7000 + 16'(k * 17), 16'h7100 + 16'(k * 3));
        end
        out_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_push === 1'b1) begin
                er = 16'h0100 + 16'(m % 16);
                ei = 16'h0200 + 16'((m / 16) * 256) + 16'(m % 16);
                checks++;
                if (out_real !== er || out_imag !== ei) begin
                    failures++;
                    $display("FAIL ignore_out m=%0d got=%h/%h exp=%h/%h", m, out_real, out_imag, er, ei);
                end
                m++;
            end
            cyc();
        end
        checks++;
        if (m != 32) begin
            failures++;
            $display("FAIL ignore_count got=%0d exp=32", m);
        end
        // A follow-up frame lands in order only if the ignored pushes left the write counter alone.
        for (int j = 0; j < 16; j++) push(16'h0100 + 16'(br4(j)), 16'h0200 + 16'(br4(j)));
        for (int i = 0; i < 16; i++) begin
            cyc();
            er = 16'h0100 + 16'(i);
            checks++;
            if (out_push !== 1'b1 || out_real !== er) begin
                failures++;
                $display("FAIL ignore_follow i=%0d got push=%b real=%h exp push=1 real=%h",
                         i, out_push, out_real, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall_two_frames();
        test_toggle_stall();
        test_reset_mid();
        test_push_while_stalled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
